// File: rtl/pipe_scroller_if.sv
// Pipe scroller bus: scene/terminal-size inputs in, pipe table and score out.
//   n_row  : terminal rows (drives recycle clamp)
//   n_col  : terminal columns (informational)
//   scene  : 0 SPLASH, 1 PLAYING, 2 GAMEOVER, 3 reserved
//   pipes  : N_PIPE slots, 24 bits each {position, max_bnd, min_bnd}
//   score  : pipes passed, saturating at 255
//   passed : one-cycle pulse per score event
interface pipe_scroller_if #(
  parameter int unsigned N_PIPE = 3
) ();
  logic [7:0]          n_row;
  logic [7:0]          n_col;
  logic [1:0]          scene;
  logic [24*N_PIPE-1:0] pipes;
  logic [7:0]          score;
  logic                passed;

  modport master (
    output n_row, n_col, scene,
    input  pipes, score, passed
  );

  modport slave (
    input  n_row, n_col, scene,
    output pipes, score, passed
  );
endinterface

// File: rtl/pipe_scroller.sv
// Generates and scrolls pipe obstacles; recycles off-screen slots with an
// LFSR-chosen gap and counts pipes passing the bird column.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : pipe_scroller_if slave (scene/n_row/n_col in; pipes/score/passed out)
module pipe_scroller #(
  parameter int unsigned N_PIPE     = 3,
  parameter int unsigned SPACING    = 50,
  parameter int unsigned GAP        = 10,
  parameter int unsigned INIT_MIN   = 15,
  parameter int unsigned BIRD_COL   = 2,
  parameter int unsigned SCROLL_DIV = 1,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input logic            clk,
  input logic            rst_n,
  pipe_scroller_if.slave bus
);

  localparam int unsigned DIV_W       = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int unsigned HIT_W       = $clog2(N_PIPE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);
  localparam logic [7:0] GAP_B        = 8'(GAP);
  localparam logic [7:0] INIT_MIN_B   = 8'(INIT_MIN);
  localparam logic [7:0] INIT_MAX_B   = 8'(INIT_MIN + GAP);
  localparam logic [7:0] RECYCLE_POS  = 8'(N_PIPE * SPACING - 1);
  localparam logic [7:0] SCORE_POS    = 8'(BIRD_COL + 1);
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;

  typedef enum logic [1:0] {
    SCENE_SPLASH   = 2'd0,
    SCENE_PLAYING  = 2'd1,
    SCENE_GAMEOVER = 2'd2,
    SCENE_RSVD     = 2'd3
  } scene_e;

  logic [7:0]       pos_q [N_PIPE];
  logic [7:0]       pos_d [N_PIPE];
  logic [7:0]       min_q [N_PIPE];
  logic [7:0]       min_d [N_PIPE];
  logic [7:0]       max_q [N_PIPE];
  logic [7:0]       max_d [N_PIPE];
  logic [7:0]       score_q, score_d;
  logic             passed_q, passed_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       lfsr_q, lfsr_d;

  logic             step;
  logic [HIT_W-1:0] hits;
  logic [8:0]       score_sum;
  logic [7:0]       rec_raw, rec_top, rec_min;
  logic [24*N_PIPE-1:0] pipes_w;
  logic [7:0]       unused_n_col;

  assign unused_n_col = bus.n_col;

  // Recycled gap floor: 2 + lfsr[4:0], clamped so max_bnd stays below n_row-2.
  always_comb begin
    rec_raw = 8'd2 + {3'b000, lfsr_q[4:0]};
    rec_top = bus.n_row - 8'd2;
    rec_min = rec_raw;
    if (rec_raw + GAP_B > rec_top) rec_min = rec_top - GAP_B;
  end

  // Next-state: LFSR free-runs; slots/score/divider follow the scene.
  always_comb begin
    lfsr_d    = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
    pos_d     = pos_q;
    min_d     = min_q;
    max_d     = max_q;
    score_d   = score_q;
    div_d     = div_q;
    passed_d  = 1'b0;
    step      = 1'b0;
    hits      = '0;
    score_sum = '0;

    case (scene_e'(bus.scene))
      SCENE_SPLASH: begin
        for (int i = 0; i < N_PIPE; i++) begin
          pos_d[i] = 8'(SPACING * (i + 1));
          min_d[i] = INIT_MIN_B;
          max_d[i] = INIT_MAX_B;
        end
        score_d = '0;
        div_d   = '0;
      end
      SCENE_PLAYING: begin
        if (div_q == DIV_LAST) begin
          step  = 1'b1;
          div_d = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: ;
    endcase

    if (step) begin
      for (int i = 0; i < N_PIPE; i++) begin
        if (pos_q[i] == SCORE_POS) hits = hits + HIT_W'(1);
        if (pos_q[i] == 8'd0) begin
          pos_d[i] = RECYCLE_POS;
          min_d[i] = rec_min;
          max_d[i] = rec_min + GAP_B;
        end else begin
          pos_d[i] = pos_q[i] - 8'd1;
        end
      end
      score_sum = {1'b0, score_q} + 9'(hits);
      score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
      passed_d  = (hits != '0);
    end
  end

  // State registers; reset restores the initial layout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PIPE; i++) begin
        pos_q[i] <= 8'(SPACING * (i + 1));
        min_q[i] <= INIT_MIN_B;
        max_q[i] <= INIT_MAX_B;
      end
      score_q  <= '0;
      passed_q <= 1'b0;
      div_q    <= '0;
      lfsr_q   <= LFSR_SEED;
    end else begin
      pos_q    <= pos_d;
      min_q    <= min_d;
      max_q    <= max_d;
      score_q  <= score_d;
      passed_q <= passed_d;
      div_q    <= div_d;
      lfsr_q   <= lfsr_d;
    end
  end

  // Pack registered slot state into the shared bus format.
  always_comb begin
    pipes_w = '0;
    for (int i = 0; i < N_PIPE; i++) begin
      pipes_w[24*i+16 +: 8] = pos_q[i];
      pipes_w[24*i+8  +: 8] = max_q[i];
      pipes_w[24*i    +: 8] = min_q[i];
    end
  end

  assign bus.pipes  = pipes_w;
  assign bus.score  = score_q;
  assign bus.passed = passed_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Self-checking bench for pipe_scroller: reference model feeds a scoreboard
// every cycle, plus directed checks of layout, scoring, recycle, clamp,
// freeze, mid-run reset and score saturation.
module tb_pipe_scroller;

  localparam int N_PIPE     = 3;
  localparam int SPACING    = 50;
  localparam int GAP        = 10;
  localparam int INIT_MIN   = 15;
  localparam int BIRD_COL   = 2;
  localparam int SCROLL_DIV = 1;
  localparam logic [7:0] SEED = 8'hA5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_scroller_if #(.N_PIPE(N_PIPE)) bus ();

  pipe_scroller #(
    .N_PIPE(N_PIPE), .SPACING(SPACING), .GAP(GAP), .INIT_MIN(INIT_MIN),
    .BIRD_COL(BIRD_COL), .SCROLL_DIV(SCROLL_DIV), .LFSR_SEED(SEED)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int         m_pos [N_PIPE];
  int         m_min [N_PIPE];
  int         m_max [N_PIPE];
  int         m_score;
  int         m_div;
  logic [7:0] m_lfsr;
  logic       m_passed;

  logic [80:0] sb_q [$];

  task automatic model_layout();
    for (int i = 0; i < N_PIPE; i++) begin
      m_pos[i] = SPACING * (i + 1);
      m_min[i] = INIT_MIN;
      m_max[i] = INIT_MIN + GAP;
    end
  endtask

  task automatic model_clock(input logic r, input logic [1:0] sc, input int nr);
    logic [7:0] nxt;
    int hits, m;
    nxt = {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
    if (!r) begin
      model_layout();
      m_score = 0; m_passed = 1'b0; m_div = 0; m_lfsr = SEED;
      return;
    end
    m_passed = 1'b0;
    if (sc == 2'd0) begin
      model_layout();
      m_score = 0;
      m_div = 0;
    end else if (sc == 2'd1) begin
      if (m_div == SCROLL_DIV - 1) begin
        m_div = 0;
        hits = 0;
        for (int i = 0; i < N_PIPE; i++) begin
          if (m_pos[i] == BIRD_COL + 1) hits++;
          if (m_pos[i] == 0) begin
            m_pos[i] = N_PIPE * SPACING - 1;
            m = 2 + int'(m_lfsr[4:0]);
            if (m + GAP > nr - 2) m = nr - 2 - GAP;
            m_min[i] = m;
            m_max[i] = m + GAP;
          end else begin
            m_pos[i] = m_pos[i] - 1;
          end
        end
        m_score = (m_score + hits > 255) ? 255 : m_score + hits;
        m_passed = (hits != 0);
      end else begin
        m_div++;
      end
    end
    m_lfsr = nxt;
  endtask

  function automatic logic [80:0] model_word();
    logic [71:0] pv;
    pv = '0;
    for (int i = 0; i < N_PIPE; i++) begin
      pv[24*i+16 +: 8] = 8'(m_pos[i]);
      pv[24*i+8  +: 8] = 8'(m_max[i]);
      pv[24*i    +: 8] = 8'(m_min[i]);
    end
    return {pv, 8'(m_score), m_passed};
  endfunction

  function automatic logic [71:0] reset_pipes();
    logic [71:0] pv;
    pv = '0;
    for (int i = 0; i < N_PIPE; i++) begin
      pv[24*i+16 +: 8] = 8'(50 * (i + 1));
      pv[24*i+8  +: 8] = 8'd25;
      pv[24*i    +: 8] = 8'd15;
    end
    return pv;
  endfunction

  function automatic int dut_field(input int i, input int off);
    return int'(bus.pipes[24*i+off +: 8]);
  endfunction

  // Drive one cycle: push model expectation, clock, then pop and compare.
  task automatic cyc(input logic r, input logic [1:0] sc, input int nr);
    logic [80:0] exp;
    rst_n     = r;
    bus.scene = sc;
    bus.n_row = 8'(nr);
    model_clock(r, sc, nr);
    sb_q.push_back(model_word());
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    check("sb", 96'({bus.pipes, bus.score, bus.passed}), 96'(exp));
  endtask

  int          pulses;
  int          recycles;
  logic [80:0] snap;

  initial begin
    rst_n     = 1'b0;
    bus.scene = 2'd0;
    bus.n_row = 8'd40;
    bus.n_col = 8'd80;
    m_lfsr    = SEED;

    // Reset values
    repeat (2) cyc(1'b0, 2'd0, 40);
    for (int i = 0; i < N_PIPE; i++) begin
      check($sformatf("rst_pos%0d", i), 96'(dut_field(i, 16)), 96'(50 * (i + 1)));
      check($sformatf("rst_min%0d", i), 96'(dut_field(i, 0)), 96'(15));
      check($sformatf("rst_max%0d", i), 96'(dut_field(i, 8)), 96'(25));
    end
    check("rst_score", 96'(bus.score), 96'(0));
    check("rst_passed", 96'(bus.passed), 96'(0));

    // SPLASH hold
    repeat (100) cyc(1'b1, 2'd0, 40);
    check("splash_pipes", 96'(bus.pipes), 96'(reset_pipes()));

    // Scoring: 48 steps
    pulses = 0;
    repeat (48) begin
      cyc(1'b1, 2'd1, 40);
      if (bus.passed) pulses++;
    end
    check("score_pos0", 96'(dut_field(0, 16)), 96'(2));
    check("score_pos1", 96'(dut_field(1, 16)), 96'(52));
    check("score_pos2", 96'(dut_field(2, 16)), 96'(102));
    check("score_val", 96'(bus.score), 96'(1));
    check("score_pulses", 96'(pulses), 96'(1));

    // Recycle at step 51
    repeat (3) cyc(1'b1, 2'd1, 40);
    check("rec_pos0", 96'(dut_field(0, 16)), 96'(149));
    check("rec_pos1", 96'(dut_field(1, 16)), 96'(49));
    check("rec_pos2", 96'(dut_field(2, 16)), 96'(99));
    check("rec_gap0", 96'(dut_field(0, 8) - dut_field(0, 0)), 96'(10));
    check("rec_min_le28", 96'(dut_field(0, 0) <= 28), 96'(1));

    // Clamp with n_row=20
    recycles = 0;
    repeat (400) begin
      cyc(1'b1, 2'd1, 20);
      for (int i = 0; i < N_PIPE; i++) begin
        if (dut_field(i, 16) == 149) begin
          recycles++;
          check($sformatf("clamp_min%0d", i), 96'(dut_field(i, 0) <= 8), 96'(1));
          check($sformatf("clamp_max%0d", i), 96'(dut_field(i, 8)), 96'(dut_field(i, 0) + 10));
        end
      end
    end
    check("clamp_seen", 96'(recycles >= 6), 96'(1));

    // Freeze in GAMEOVER and reserved scene
    repeat (30) cyc(1'b1, 2'd1, 40);
    snap = model_word();
    repeat (200) cyc(1'b1, 2'd2, 40);
    check("frz_pipes", 96'(bus.pipes), 96'(snap[80:9]));
    check("frz_score", 96'(bus.score), 96'(snap[8:1]));
    check("frz_passed", 96'(bus.passed), 96'(0));
    repeat (20) cyc(1'b1, 2'd3, 40);
    check("rsvd_pipes", 96'(bus.pipes), 96'(snap[80:9]));

    // Mid-run reset during PLAYING
    repeat (10) cyc(1'b1, 2'd1, 40);
    cyc(1'b0, 2'd1, 40);
    check("mrst_pipes", 96'(bus.pipes), 96'(reset_pipes()));
    check("mrst_score", 96'(bus.score), 96'(0));

    // Score saturation
    repeat (13000) cyc(1'b1, 2'd1, 40);
    check("sat_score", 96'(bus.score), 96'(255));

    // PLAYING -> SPLASH re-initialises
    cyc(1'b1, 2'd0, 40);
    check("splash_reinit", 96'(bus.pipes), 96'(reset_pipes()));
    check("splash_score", 96'(bus.score), 96'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
